approx_prod_accum: RTL and testbench
====================================

// Module: approx_prod_accum
// PURPOSE
//   Streaming accumulator that sits directly downstream of the 8x8 unsigned approximate
//   multipliers. It consumes one 16-bit product per accepted beat over a valid/ready
//   handshake and sums a dot product of up to LEN terms. It emits the sum, a term count
//   and a saturation flag over a second valid/ready handshake. Used to measure
//   approximate-product error at the dot-product level and to feed the MAC datapath.
// PARAMETERS
//   PROD_W   16   width of incoming product (matches 8x8 multiplier z output)
//   ACC_W    24   accumulator / result width; must be > PROD_W
//   LEN      16   terms per dot product when no early in_last; 1..255
//   CNT_W    8    width of term counter and out_cnt
//   BIAS     0    unsigned per-term compensation constant, PROD_W bits (used only with macro)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        product beat valid
//   in_ready   out  1        accumulator can accept a beat
//   in_data    in   PROD_W   product z from multiplier
//   in_last    in   1        beat is final term of this dot product
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_data   out  ACC_W    accumulated sum (saturated)
//   out_cnt    out  CNT_W    number of terms summed (1..LEN)
//   out_sat    out  1        sum clamped at 2^ACC_W-1 at least once
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, acc=0, cnt=0, sat=0, in_ready=0 for that cycle.
//     After reset: out_valid=0, out_data=0, out_cnt=0, out_sat=0, in_ready=1.
//     Reset mid-operation discards any partial sum and any pending result.
//   - FSM: IDLE -> ACCUM on first accepted beat. ACCUM -> OUT when the accepted beat is
//     the LEN-th beat or carries in_last. OUT -> IDLE when out_valid && out_ready.
//   - in_ready=1 in IDLE and ACCUM; in_ready=0 in OUT. Beats are never dropped or duplicated.
//   - Accept = in_valid && in_ready. On accept: term = in_data (+BIAS, see CONFIGURATION),
//     zero-extended to ACC_W+1. Then acc_next = acc + term, and cnt = cnt + 1.
//   - Saturation: if acc_next >= 2^ACC_W, acc := 2^ACC_W-1 and sat := 1. Once saturated,
//     acc stays at max for the rest of the dot product.
//   - A beat that is both first and final (in_last in IDLE, or LEN=1) yields out_cnt=1.
//   - Latency: out_valid rises the cycle after the final beat is accepted.
//     out_data, out_cnt and out_sat are registered and stable while out_valid=1 && !out_ready.
//   - Leaving OUT clears acc, cnt and sat. The next beat is accepted the cycle after the
//     result handshake. Throughput is one result per (terms+1) cycles.
//   - in_valid in OUT is held off (in_ready=0). in_data, in_last and in_valid are don't-care
//     when in_ready=0.
//   - out_valid falls the cycle after the handshake. out_data, out_cnt and out_sat hold
//     their last value until the next result.
// CONFIGURATION
//   APPROX_BIAS_COMP_EN defined: each accepted term is in_data + BIAS, done in PROD_W+1 bits
//     before accumulation. This offsets the mean negative error of the truncated
//     approximate products. It adds one adder on the input path and no extra cycle.
//   APPROX_BIAS_COMP_EN undefined: term = in_data. BIAS is ignored and no adder is built.
// STRUCTURE
//   - Shared package approx_mult_pkg holds: PROD_W/ACC_W defaults, the state enum
//     (IDLE, ACCUM, OUT), and the sat_add helper constant (ACC_MAX = 2^ACC_W-1).
//   - Sub-module sat_accum_add is natural: combinational saturating add of term into acc.
//     It returns {sum, ovf}. It is reused by the signed accumulator variant.
//   - Top holds the FSM, the counter and the output registers.
// TESTING  (LEN=4, ACC_W=24, macro off unless stated)
//   1. Reset then products 100,200,300,400, no in_last -> one result: out_data=1000, out_cnt=4, out_sat=0.
//   2. Beats 65535,1 with in_last on beat 2 -> out_data=65536, out_cnt=2; in_ready=0 while out_valid.
//   3. out_ready low 5 cycles after out_valid -> outputs stable and in_ready=0; release -> next sum accepted.
//   4. ACC_W=17, beats 65535,65535,65535 with in_last on the third beat -> out_data=131071, out_sat=1, out_cnt=3.
//   5. rst pulsed after 2 of 4 beats -> no result. Fresh 4 beats of 10 -> out_data=40, out_cnt=4.
//   6. Macro on, BIAS=8, beats 0,0,0,0 -> out_data=32. Macro off, same beats -> out_data=0.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types and defaults for the approximate-multiplier datapath blocks.
// Holds the accumulator FSM state encoding and the saturation ceiling.
package approx_mult_pkg;

   localparam int PROD_W_DEF = 16;
   localparam int ACC_W_DEF  = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   // Saturation ceiling for the default accumulator width (2^ACC_W-1).
   localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;

endpackage

// File: rtl/sat_accum_add.sv
// Combinational saturating add of an unsigned term into an unsigned accumulator.
// Returns the clamped sum and an overflow flag; TERM_W must not exceed ACC_W.
module sat_accum_add #(
   parameter int ACC_W  = 24,
   parameter int TERM_W = 17
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [TERM_W-1:0] i_term,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_ovf
);

   logic [ACC_W:0] w_wide;

   // One guard bit above the accumulator catches any carry out.
   assign w_wide = {1'b0, i_acc} + {{(ACC_W + 1 - TERM_W){1'b0}}, i_term};
   assign o_ovf  = w_wide[ACC_W];
   assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];

endmodule

// File: rtl/approx_prod_accum.sv
// Streaming saturating dot-product accumulator for approximate 8x8 products.
// Optional per-term bias compensation is enabled by defining APPROX_BIAS_COMP_EN.
module approx_prod_accum
   import approx_mult_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN    = 16,
   parameter int CNT_W  = 8,
   parameter int BIAS   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_sat,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and in_ready is low whenever a result is held.

   state_t             r_state;
   state_t             w_next_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sat;
   logic [ACC_W-1:0]   r_out_data;
   logic [CNT_W-1:0]   r_out_cnt;
   logic               r_out_sat;

   logic               w_accept;
   logic               w_final;
   logic               w_leave_out;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [PROD_W:0]    w_term;
   logic [ACC_W-1:0]   w_sum;
   logic               w_ovf;

`ifdef APPROX_BIAS_COMP_EN
   assign w_term = {1'b0, in_data} + (PROD_W + 1)'(BIAS);
`else
   assign w_term = {1'b0, in_data};
`endif

   assign in_ready    = !rst && (r_state != OUT);
   assign w_accept    = in_valid && in_ready;
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_final     = in_last || (w_cnt_inc == CNT_W'(LEN));
   assign w_leave_out = (r_state == OUT) && out_ready;

   sat_accum_add #(
      .ACC_W  (ACC_W),
      .TERM_W (PROD_W + 1)
   ) u_add (
      .i_acc  (r_acc),
      .i_term (w_term),
      .o_sum  (w_sum),
      .o_ovf  (w_ovf)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, ACCUM: if (w_accept) w_next_state = w_final ? OUT : ACCUM;
         OUT:         if (out_ready) w_next_state = IDLE;
         default:     w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sat      <= 1'b0;
         r_out_data <= '0;
         r_out_cnt  <= '0;
         r_out_sat  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_leave_out) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_sat <= r_sat | w_ovf;
            if (w_final) begin
               r_out_data <= w_sum;
               r_out_cnt  <= w_cnt_inc;
               r_out_sat  <= r_sat | w_ovf;
            end
         end
      end
   end

   assign out_valid = (r_state == OUT);
   assign out_data  = r_out_data;
   assign out_cnt   = r_out_cnt;
   assign out_sat   = r_out_sat;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Bench for approx_prod_accum: a 24-bit and a 17-bit instance share one input stream.
// Table vectors, hand-written reset/backpressure sequences and random dot products.
module tb_approx_prod_accum;
   import approx_mult_pkg::*;

`ifdef APPROX_BIAS_COMP_EN
   localparam int TB_BIAS = 8;
`else
   localparam int TB_BIAS = 0;
`endif
   localparam longint MAX_A = (64'd1 << 24) - 1;
   localparam longint MAX_B = (64'd1 << 17) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_sat_a;
   logic [23:0] out_data_a;
   logic [7:0]  out_cnt_a;
   state_t      state_a;
   logic        in_ready_b, out_valid_b, out_sat_b;
   logic [16:0] out_data_b;
   logic [7:0]  out_cnt_b;
   state_t      state_b;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] q[$];

   always #5 clk = ~clk;

   approx_prod_accum #(.PROD_W(16), .ACC_W(24), .LEN(4), .CNT_W(8), .BIAS(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_cnt(out_cnt_a),
      .out_sat(out_sat_a), .dbg_state(state_a)
   );

   approx_prod_accum #(.PROD_W(16), .ACC_W(17), .LEN(4), .CNT_W(8), .BIAS(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_cnt(out_cnt_b),
      .out_sat(out_sat_b), .dbg_state(state_b)
   );

   typedef struct packed {
      logic [2:0]       n;
      logic [3:0][15:0] d;
      logic             last;
      logic [3:0]       hold;
      logic [23:0]      exp_base;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                               input int d3, input bit last, input int hold, input int e);
      vec_t v;
      v.n = 3'(n);
      v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2); v.d[3] = 16'(d3);
      v.last = last;
      v.hold = 4'(hold);
      v.exp_base = 24'(e);
      return v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain unbounded sum with a clamp at the width's ceiling.
   function automatic longint model_sum(input int acc_w, output bit sat);
      longint s, mx;
      mx = (64'd1 << acc_w) - 1;
      s = 0;
      sat = 0;
      foreach (q[i]) begin
         s = s + longint'(q[i]) + TB_BIAS;
         if (s > mx) begin
            s = mx;
            sat = 1;
         end
      end
      return s;
   endfunction

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send_beat(input logic [15:0] d, input bit last);
      int budget = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready_a && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic collect(input string name, input int hold, input longint ea, input bit sa,
                          input longint eb, input bit sb, input int ec);
      int waited = 0;
      out_ready = 1'b0;
      while (!out_valid_a && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_latency"}, waited, 0);
      check({name, "_valid_b"}, out_valid_b, 1);
      check({name, "_in_ready_held"}, {in_ready_a, in_ready_b}, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "_hold_valid"}, out_valid_a, 1);
         check({name, "_hold_ready"}, in_ready_a, 0);
         check({name, "_hold_data"}, out_data_a, ea);
      end
      check({name, "_data_a"}, out_data_a, ea);
      check({name, "_cnt_a"}, out_cnt_a, ec);
      check({name, "_sat_a"}, out_sat_a, sa);
      check({name, "_data_b"}, out_data_b, eb);
      check({name, "_cnt_b"}, out_cnt_b, ec);
      check({name, "_sat_b"}, out_sat_b, sb);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_valid_drop"}, out_valid_a, 0);
      check({name, "_ready_back"}, in_ready_a, 1);
      check({name, "_data_kept"}, out_data_a, ea);
   endtask

   initial begin
      longint ea, eb;
      bit sa, sb, last;
      int n;

      vecs[0] = mk(4, 100, 200, 300, 400, 0, 0, 1000);
      vecs[1] = mk(2, 65535, 1, 0, 0, 1, 0, 65536);
      vecs[2] = mk(4, 1, 2, 3, 4, 0, 5, 10);
      vecs[3] = mk(3, 65535, 65535, 65535, 0, 1, 0, 196605);
      vecs[4] = mk(4, 0, 0, 0, 0, 0, 0, 0);
      vecs[5] = mk(1, 7, 0, 0, 0, 1, 2, 7);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready_a, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_out_data", out_data_a, 0);
      check("rst_out_cnt", out_cnt_a, 0);
      check("rst_out_sat", out_sat_a, 0);
      check("rst_in_ready_after", in_ready_a, 1);
      check("rst_state", state_a, IDLE);

      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < int'(vecs[i].n); b++)
            send_beat(vecs[i].d[b], vecs[i].last && (b == int'(vecs[i].n) - 1));
         ea = longint'(vecs[i].exp_base) + TB_BIAS * int'(vecs[i].n);
         eb = (ea > MAX_B) ? MAX_B : ea;
         collect($sformatf("vec%0d", i), int'(vecs[i].hold), ea, 0, eb, ea > MAX_B,
                 int'(vecs[i].n));
      end

      // Reset in the middle of a dot product leaves no result behind.
      send_beat(16'd10, 0);
      send_beat(16'd10, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready_a, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_result", out_valid_a, 0);
      end
      check("midrst_out_cnt", out_cnt_a, 0);
      for (int b = 0; b < 4; b++) send_beat(16'd10, 0);
      collect("midrst_fresh", 0, 40 + 4 * TB_BIAS, 0, 40 + 4 * TB_BIAS, 0, 4);

      for (int t = 0; t < 25; t++) begin
         n = $urandom_range(1, 4);
         last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
         q.delete();
         for (int b = 0; b < n; b++)
            q.push_back(($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - $urandom_range(0, 15))
                                                    : 16'($urandom));
         ea = model_sum(24, sa);
         eb = model_sum(17, sb);
         for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(q[b], last && (b == n - 1));
         end
         collect($sformatf("rand%0d", t), $urandom_range(0, 3), ea, sa, eb, sb, n);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end expected end");
      $fatal(1);
   end

endmodule
